// File: rtl/atpg_pkg.sv
// Shared types and constants for the ATPG vector-apply harness around c5315.
// Holds the checker FSM encoding, the default MISR polynomial and seed, and chunk math.
package atpg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int C5315_OUT_W = 123;
    localparam int C5315_IN_W  = 178;

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

    // Number of sig-wide chunks needed to cover a data word (top chunk zero-padded).
    function automatic int num_chunks(input int data_w, input int sig_w);
        return (data_w + sig_w - 1) / sig_w;
    endfunction

endpackage

// File: rtl/atpg_misr.sv
// Multiple-input signature register: XOR-folds a wide data word down to SIG_W bits
// and mixes it into a Galois LFSR step. load restores the seed; en advances one step.
module atpg_misr
    import atpg_pkg::*;
#(
    parameter int               DATA_W = C5315_OUT_W,
    parameter int               SIG_W  = 32,
    parameter logic [SIG_W-1:0] POLY   = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [SIG_W-1:0]  sig
);

    localparam int NCH   = num_chunks(DATA_W, SIG_W);
    localparam int PAD_W = NCH * SIG_W;

    logic [PAD_W-1:0]          data_pad;
    logic [NCH:0][SIG_W-1:0]   fold_acc;
    logic [SIG_W-1:0]          sig_q;
    logic [SIG_W-1:0]          sig_d;

    assign data_pad    = PAD_W'(data);
    assign fold_acc[0] = '0;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_fold
            assign fold_acc[gi+1] = fold_acc[gi] ^ data_pad[gi*SIG_W +: SIG_W];
        end
    endgenerate

    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ fold_acc[NCH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/atpg_response_checker.sv
// Consumes per-vector c5315 responses, compares them against golden data under an X-mask,
// compacts the raw responses into a MISR signature and reports a pass/fail run summary.
module atpg_response_checker
    import atpg_pkg::*;
#(
    parameter int               OUT_W = C5315_OUT_W,
    parameter int               SIG_W = 32,
    parameter int               CNT_W = 16,
    parameter logic [SIG_W-1:0] POLY  = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic [OUT_W-1:0] resp_data,
    input  logic [OUT_W-1:0] exp_data,
    input  logic [OUT_W-1:0] exp_mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] accepted
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] accepted_q, accepted_d;
    logic [CNT_W-1:0] fail_count_q, fail_count_d;
    logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
    logic             pass_q, pass_d;
    logic             resp_ready_q, resp_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             misr_load;
    logic             misr_en;
    logic             mismatch;

    assign mismatch = |((resp_data ^ exp_data) & exp_mask);

    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        accepted_d       = accepted_q;
        fail_count_d     = fail_count_q;
        first_fail_idx_d = first_fail_idx_q;
        pass_d           = pass_q;
        misr_load        = 1'b0;
        misr_en          = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d         = num_vectors;
                    accepted_d       = '0;
                    fail_count_d     = '0;
                    first_fail_idx_d = CNT_MAX;
                    misr_load        = 1'b1;
                    if (num_vectors == '0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                // resp_ready is exactly (state_q == RUN), so a valid beat here is a handshake.
                if (resp_valid) begin
                    misr_en    = 1'b1;
                    accepted_d = accepted_q + CNT_W'(1);
                    if (mismatch) begin
                        if (fail_count_q != CNT_MAX) begin
                            fail_count_d = fail_count_q + CNT_W'(1);
                        end
                        if (fail_count_q == '0) begin
                            first_fail_idx_d = accepted_q;
                        end
                    end
                    if (accepted_d == target_q) begin
                        state_d = DONE;
                        pass_d  = (fail_count_d == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        resp_ready_d = (state_d == RUN);
        busy_d       = (state_d == RUN);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            target_q         <= '0;
            accepted_q       <= '0;
            fail_count_q     <= '0;
            first_fail_idx_q <= CNT_MAX;
            pass_q           <= 1'b0;
            resp_ready_q     <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            target_q         <= target_d;
            accepted_q       <= accepted_d;
            fail_count_q     <= fail_count_d;
            first_fail_idx_q <= first_fail_idx_d;
            pass_q           <= pass_d;
            resp_ready_q     <= resp_ready_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    atpg_misr #(
        .DATA_W (OUT_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (misr_load),
        .en   (misr_en),
        .data (resp_data),
        .sig  (signature)
    );

    assign resp_ready     = resp_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = first_fail_idx_q;
    assign accepted       = accepted_q;

endmodule

// File: tb/tb_atpg_response_checker.sv
// Randomized scoreboard bench for atpg_response_checker: the stimulus process pushes the
// expected run summary, and a monitor pops and compares each time done rises.
module tb_atpg_response_checker;

    localparam int OUT_W = 123;
    localparam int SIG_W = 32;
    localparam int CNT_W = 16;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             resp_valid;
    logic             resp_ready;
    logic [OUT_W-1:0] resp_data;
    logic [OUT_W-1:0] exp_data;
    logic [OUT_W-1:0] exp_mask;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] fail_count;
    logic [CNT_W-1:0] first_fail_idx;
    logic [SIG_W-1:0] signature;
    logic [CNT_W-1:0] accepted;

    always #5 clk = ~clk;

    atpg_response_checker dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_vectors    (num_vectors),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .exp_data       (exp_data),
        .exp_mask       (exp_mask),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .signature      (signature),
        .accepted       (accepted)
    );

    typedef struct {
        logic        pass;
        logic [15:0] fails;
        logic [15:0] first;
        logic [31:0] sig;
        logic [15:0] acc;
    } exp_t;

    exp_t             sb[$];
    logic [OUT_W-1:0] vec_r[$];
    logic [OUT_W-1:0] vec_e[$];
    logic [OUT_W-1:0] vec_m[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               run_no   = 0;
    logic [OUT_W-1:0] all_ones;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [OUT_W-1:0] rand_vec();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[OUT_W-1:0];
    endfunction

    // Reference: signature from the arithmetic definition (fold of 32-bit chunks, shift, poly).
    function automatic exp_t model_run();
        exp_t        e;
        logic [31:0] s;
        logic [31:0] fold;
        logic [127:0] padded;
        int          fails;
        s     = SEED;
        fails = 0;
        e.first = 16'hFFFF;
        for (int i = 0; i < vec_r.size(); i++) begin
            padded = 128'(vec_r[i]);
            fold   = 32'h0;
            for (int k = 0; k < 4; k++) fold = fold ^ 32'(padded >> (32 * k));
            s = ((s << 1) ^ (s[31] ? POLY : 32'h0)) ^ fold;
            if (((vec_r[i] ^ vec_e[i]) & vec_m[i]) != '0) begin
                if (fails == 0) e.first = 16'(i);
                if (fails < 65535) fails++;
            end
        end
        e.fails = 16'(fails);
        e.pass  = (fails == 0);
        e.sig   = s;
        e.acc   = 16'(vec_r.size());
        return e;
    endfunction

    // Monitor: compares the run summary on every rising edge of done.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0;
            end else begin
                if (done && !done_prev) begin
                    run_no++;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL run%0d: done rose with no expected result queued", run_no);
                    end else begin
                        e = sb.pop_front();
                        $display("run %0d: acc=%0d fails=%0d first=%0h pass=%0b sig=%08h (exp sig=%08h)",
                                 run_no, accepted, fail_count, first_fail_idx, pass, signature, e.sig);
                        check("pass", 64'(pass), 64'(e.pass));
                        check("fail_count", 64'(fail_count), 64'(e.fails));
                        check("first_fail_idx", 64'(first_fail_idx), 64'(e.first));
                        check("signature", 64'(signature), 64'(e.sig));
                        check("accepted", 64'(accepted), 64'(e.acc));
                        check("resp_ready_after_done", 64'(resp_ready), 64'(0));
                        check("busy_after_done", 64'(busy), 64'(0));
                    end
                end
                done_prev = done;
            end
        end
    end

    // Drives one run of vec_r/vec_e/vec_m. Called #1 after a rising edge.
    task automatic run(input int gap_pct, input int pulse_at, input int abort_at,
                       input logic use_const, input logic [31:0] const_sig);
        exp_t e;
        int   n;
        logic was_done;
        int   guard;
        n = vec_r.size();
        if (abort_at < 0) begin
            e = model_run();
            if (use_const) e.sig = const_sig;
            sb.push_back(e);
        end
        was_done    = done;
        start       = 1'b1;
        num_vectors = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (was_done && n > 0) begin
            check("restart_done_low", 64'(done), 64'(0));
            check("restart_busy_high", 64'(busy), 64'(1));
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                resp_valid = 1'b0;
                rst        = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            while ($urandom_range(99) < gap_pct) begin
                resp_valid = 1'b0;
                resp_data  = rand_vec();
                @(posedge clk); #1;
            end
            resp_valid = 1'b1;
            resp_data  = vec_r[i];
            exp_data   = vec_e[i];
            exp_mask   = vec_m[i];
            if (i == pulse_at) begin
                start       = 1'b1;
                num_vectors = 16'd3;
            end
            guard = 0;
            @(negedge clk);
            while (!resp_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_wait: resp_ready stayed 0 at beat %0d, expected 1", i);
                resp_valid = 1'b0;
                start      = 1'b0;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        resp_valid = 1'b0;
    endtask

    task automatic clear_vecs();
        vec_r.delete();
        vec_e.delete();
        vec_m.delete();
    endtask

    task automatic build_random(input int n, input int flip_pct);
        logic [OUT_W-1:0] r;
        clear_vecs();
        for (int i = 0; i < n; i++) begin
            r = rand_vec();
            vec_r.push_back(r);
            if ($urandom_range(99) < flip_pct)
                vec_e.push_back(r ^ (OUT_W'(1) << $urandom_range(OUT_W - 1)));
            else
                vec_e.push_back(r);
            vec_m.push_back(rand_vec());
        end
    endtask

    initial begin
        int guard;
        all_ones    = '1;
        rst         = 1'b1;
        start       = 1'b0;
        num_vectors = '0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        exp_data    = '0;
        exp_mask    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp_ready", 64'(resp_ready), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_pass", 64'(pass), 64'(0));
        check("reset_fail_count", 64'(fail_count), 64'(0));
        check("reset_first_fail_idx", 64'(first_fail_idx), 64'(16'hFFFF));
        check("reset_signature", 64'(signature), 64'(SEED));
        check("reset_accepted", 64'(accepted), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-vector run: immediate done with seed signature, never ready.
        clear_vecs();
        run(0, -1, -1, 1'b1, 32'hFFFFFFFF);
        repeat (3) begin
            @(negedge clk);
            check("zero_run_ready", 64'(resp_ready), 64'(0));
        end
        @(posedge clk); #1;

        // Single all-zero response against the known golden signature.
        clear_vecs();
        vec_r.push_back('0);
        vec_e.push_back('0);
        vec_m.push_back(all_ones);
        run(0, -1, -1, 1'b1, 32'hFB3EE249);

        // Beats 3 and 7 mismatch on bit 0, first compared, then masked off.
        build_random(10, 0);
        for (int i = 0; i < 10; i++) begin
            vec_m[i] = all_ones;
            if (i == 3 || i == 7) vec_e[i] = vec_r[i] ^ OUT_W'(1);
        end
        run(0, -1, -1, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) vec_m[i] = all_ones ^ OUT_W'(1);
        run(0, -1, -1, 1'b0, 32'h0);

        // Same data gap-free then with ~50% valid gaps.
        build_random(10, 30);
        run(0, -1, -1, 1'b0, 32'h0);
        run(50, -1, -1, 1'b0, 32'h0);

        // Reset after 4 of 10 beats, then a fresh 2-beat run.
        build_random(10, 30);
        run(0, -1, 4, 1'b0, 32'h0);
        check("abort_accepted", 64'(accepted), 64'(0));
        check("abort_signature", 64'(signature), 64'(SEED));
        build_random(2, 50);
        run(0, -1, -1, 1'b0, 32'h0);

        // start pulsed mid-run with a different target must be ignored.
        build_random(10, 20);
        run(0, 5, -1, 1'b0, 32'h0);

        for (int k = 0; k < 4; k++) begin
            build_random($urandom_range(20, 1), $urandom_range(60));
            run($urandom_range(40), -1, -1, 1'b0, 32'h0);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results never reported, expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
